cla_multiword_seq: RTL

- Sequenced wide adder/subtractor that computes a WORDS*SLICE-bit result by reusing one internal SLICE-bit carry-lookahead slice over WORDS consecutive cycles.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Trades latency for area when a full-width lookahead adder is too large.

---
 rtl/cla_multiword_seq.sv | 129 ++++++++++++
 1 files changed

// File: rtl/cla_multiword_seq.sv
// Sequenced WORDS*SLICE-bit adder/subtractor: one 4-bit carry-lookahead slice
// is reused over WORDS cycles, with valid/ready handshakes on both sides.
module cla_multiword_seq #(
  parameter int unsigned SLICE = 4,
  parameter int unsigned WORDS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SLICE*WORDS-1:0] a,
  input  logic [SLICE*WORDS-1:0] b,
  input  logic                   cin,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SLICE*WORDS-1:0] sum,
  output logic                   cout,
  output logic                   ovf,
  output logic                   busy
);

  localparam int unsigned IW = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                        state_q, state_d;
  logic [WORDS-1:0][SLICE-1:0]   a_q, a_d;
  logic [WORDS-1:0][SLICE-1:0]   b_q, b_d;
  logic [WORDS-1:0][SLICE-1:0]   sum_q, sum_d;
  logic [IW-1:0]                 idx_q, idx_d;
  logic                          carry_q, carry_d;
  logic                          cout_q, cout_d;
  logic                          ovf_q, ovf_d;

  logic [SLICE-1:0]              p, g, s;
  logic [SLICE:0]                c;
  logic                          last;

  assign last = (idx_q == IW'(WORDS - 1));

  // Lookahead slice: every carry is a flat sum of products of g/p and the carry-in.
  always_comb begin
    p    = a_q[idx_q] ^ b_q[idx_q];
    g    = a_q[idx_q] & b_q[idx_q];
    c[0] = carry_q;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    s    = p ^ c[3:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last)     state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Subtraction is folded into the operand latch: B is inverted and carry-in forced to 1.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub | cin;
          idx_d   = '0;
        end
      end
      RUN: begin
        sum_d[idx_q] = s;
        carry_d      = c[4];
        if (last) begin
          cout_d = c[4];
          ovf_d  = c[3] ^ c[4];
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
